perf_mon: RTL and testbench

- Parametrised Wishbone performance monitor; a generalised successor to the fixed 2-master, 4-counter unit.
- Watches NCH Wishbone masters.
- Per channel it keeps three counters:
  - request cycles
  - acknowledged transfers
  - worst-case access latency
- Adds global enable, clear-all, atomic snapshot, overflow flags and selectable wrap/saturate mode. Software reads everything through a Wishbone slave port.

---
 rtl/perf_pkg.sv | 25 ++
 rtl/perf_chan.sv | 119 +++++++++++
 rtl/perf_mon.sv | 159 +++++++++++++++
 tb/tb_perf_mon.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/perf_pkg.sv
// Shared definitions for the Wishbone performance monitor.
// Holds the register map offsets, CTRL bit positions and the per-channel
// counter index used to address REQ / ACK / MAXLAT inside a channel block.
package perf_pkg;

    // Register offsets relative to the slave base address
    localparam logic [15:0] CTRL_OFF   = 16'h0000;
    localparam logic [15:0] STATUS_OFF = 16'h0004;
    localparam logic [15:0] CH_BASE    = 16'h0010;
    localparam logic [15:0] CH_STRIDE  = 16'h0010;

    // CTRL register bit positions
    localparam int CTRL_EN   = 0;
    localparam int CTRL_CLR  = 1;
    localparam int CTRL_SNAP = 2;
    localparam int CTRL_SHRD = 3;

    // Counter slot inside one channel (word index within the channel block)
    typedef enum logic [1:0] {
        CNT_REQ    = 2'd0,
        CNT_ACK    = 2'd1,
        CNT_MAXLAT = 2'd2
    } cnt_idx_e;

endpackage

// File: rtl/perf_chan.sv
// One monitored master: request / acknowledge counters, worst-case latency
// tracker, snapshot shadows and overflow pulses.
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_en                counting enable (latency tracker runs regardless)
//   i_clr_all           clear all counters and the running latency
//   i_snap              copy every live counter into its shadow
//   i_cnt_clr[2:0]      clear one counter (indexed by cnt_idx_e)
//   i_mon_cyc/stb/ack   monitored master signals
//   o_live, o_shadow    live and shadow counter values
//   o_ovf[2:0]          registered one-cycle overflow pulses
module perf_chan import perf_pkg::*; #(
    parameter int CW  = 32,
    parameter bit SAT = 1'b0
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_en,
    input  logic                 i_clr_all,
    input  logic                 i_snap,
    input  logic [2:0]           i_cnt_clr,
    input  logic                 i_mon_cyc,
    input  logic                 i_mon_stb,
    input  logic                 i_mon_ack,
    output logic [2:0][CW-1:0]   o_live,
    output logic [2:0][CW-1:0]   o_shadow,
    output logic [2:0]           o_ovf
);

    localparam logic [CW-1:0] ONES = {CW{1'b1}};
    localparam logic [CW-1:0] ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] ONE  = {{(CW-1){1'b0}}, 1'b1};

    logic [2:0][CW-1:0] r_cnt;
    logic [2:0][CW-1:0] r_shadow;
    logic [CW-1:0]      r_cur;
    logic [2:0]         r_ovf;

    logic [CW-1:0] w_req_nxt, w_ack_nxt, w_max_nxt, w_cur_nxt, w_lat;
    logic          w_req_ovf, w_ack_ovf, w_max_ovf;
    logic          w_inc_req, w_inc_ack, w_lat_evt;

    // Clear beats increment; an increment from all-ones flags overflow and
    // then either wraps or sticks depending on SAT. Returns {ovf, next}.
    function automatic logic [CW:0] cnt_step(input logic [CW-1:0] cnt,
                                             input logic clr, input logic inc);
        if (clr) begin
            cnt_step = {1'b0, ZERO};
        end else if (inc && cnt == ONES) begin
            cnt_step = {1'b1, (SAT ? ONES : ZERO)};
        end else if (inc) begin
            cnt_step = {1'b0, cnt + ONE};
        end else begin
            cnt_step = {1'b0, cnt};
        end
    endfunction

    assign w_inc_req = i_en & i_mon_cyc & i_mon_stb;
    assign w_inc_ack = i_en & i_mon_cyc & i_mon_ack;
    assign w_lat_evt = i_en & i_mon_cyc & i_mon_stb & i_mon_ack;

    assign {w_req_ovf, w_req_nxt} = cnt_step(r_cnt[CNT_REQ], i_clr_all | i_cnt_clr[CNT_REQ], w_inc_req);
    assign {w_ack_ovf, w_ack_nxt} = cnt_step(r_cnt[CNT_ACK], i_clr_all | i_cnt_clr[CNT_ACK], w_inc_ack);

    // Latency of the completing access; saturated waits yield an all-ones candidate
    assign w_lat = (r_cur == ONES) ? ONES : (r_cur + ONE);

    // Worst-case latency update, gated by EN and overridden by any clear
    always_comb begin
        w_max_nxt = r_cnt[CNT_MAXLAT];
        w_max_ovf = 1'b0;
        if (i_clr_all || i_cnt_clr[CNT_MAXLAT]) begin
            w_max_nxt = ZERO;
        end else if (w_lat_evt) begin
            w_max_ovf = (w_lat == ONES);
            w_max_nxt = (w_lat > r_cnt[CNT_MAXLAT]) ? w_lat : r_cnt[CNT_MAXLAT];
        end else begin
            w_max_nxt = r_cnt[CNT_MAXLAT];
        end
    end

    // Running wait-cycle count of the current access; dropping cyc aborts it
    always_comb begin
        w_cur_nxt = r_cur;
        if (i_clr_all || !i_mon_cyc) begin
            w_cur_nxt = ZERO;
        end else if (i_mon_stb && !i_mon_ack) begin
            w_cur_nxt = (r_cur == ONES) ? ONES : (r_cur + ONE);
        end else if (i_mon_stb && i_mon_ack) begin
            w_cur_nxt = ZERO;
        end else begin
            w_cur_nxt = r_cur;
        end
    end

    // State registers: counters, tracker, shadows and overflow pulses
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt    <= {(3*CW){1'b0}};
            r_shadow <= {(3*CW){1'b0}};
            r_cur    <= ZERO;
            r_ovf    <= 3'b000;
        end else begin
            r_cnt[CNT_REQ]    <= w_req_nxt;
            r_cnt[CNT_ACK]    <= w_ack_nxt;
            r_cnt[CNT_MAXLAT] <= w_max_nxt;
            r_cur             <= w_cur_nxt;
            r_ovf             <= {w_max_ovf, w_ack_ovf, w_req_ovf};
            if (i_snap) begin
                r_shadow <= r_cnt;
            end
        end
    end

    assign o_live   = r_cnt;
    assign o_shadow = r_shadow;
    assign o_ovf    = r_ovf;

endmodule

// File: rtl/perf_mon.sv
// Wishbone performance monitor top: slave decode, CTRL/STATUS registers,
// read mux, and NCH perf_chan instances.
// Ports:
//   i_clk, i_rst                 clock, synchronous active-high reset
//   i_wb_cyc/stb/we/adr/dat/sel  slave request (sel ignored, full words)
//   o_wb_dat, o_wb_ack           registered read data and acknowledge
//   o_wb_err, o_wb_rty           always 0
//   i_mon_cyc/stb/ack[NCH]       monitored masters, bit i = channel i
module perf_mon import perf_pkg::*; #(
    parameter int          NCH  = 2,
    parameter int          CW   = 32,
    parameter bit          SAT  = 1'b0,
    parameter logic [31:0] BASE = 32'h9900_0000
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_wb_cyc,
    input  logic            i_wb_stb,
    input  logic            i_wb_we,
    input  logic [31:0]     i_wb_adr,
    input  logic [31:0]     i_wb_dat,
    input  logic [3:0]      i_wb_sel,
    output logic [31:0]     o_wb_dat,
    output logic            o_wb_ack,
    output logic            o_wb_err,
    output logic            o_wb_rty,
    input  logic [NCH-1:0]  i_mon_cyc,
    input  logic [NCH-1:0]  i_mon_stb,
    input  logic [NCH-1:0]  i_mon_ack
);

    localparam int SW = 3 * NCH;

    logic              r_ack, r_en, r_shrd;
    logic [31:0]       r_dat;
    logic [SW-1:0]     r_status;

    logic              w_acc, w_wr, w_hit, w_is_ctrl, w_is_stat, w_is_chan;
    logic              w_clr_all, w_snap, w_unused;
    logic [15:0]       w_off, w_rel, w_ch_idx;
    logic [1:0]        w_k;
    logic [31:0]       w_rd;
    logic [SW-1:0]     w_ovf;
    logic [NCH-1:0][2:0][CW-1:0] w_live, w_shadow;
    logic [NCH-1:0][2:0]         w_cnt_clr;
    logic [NCH-1:0][31:0]        w_ch_val;
    logic [NCH:0][31:0]          w_or;

    // Pick one counter of a channel, live or shadow, zero-extended to 32 bits
    function automatic logic [31:0] pick(input logic [2:0][CW-1:0] live,
                                         input logic [2:0][CW-1:0] shdw,
                                         input logic shrd, input logic [1:0] k);
        logic [2:0][CW-1:0] src;
        src = shrd ? shdw : live;
        case (k)
            CNT_REQ:    pick = 32'(src[CNT_REQ]);
            CNT_ACK:    pick = 32'(src[CNT_ACK]);
            CNT_MAXLAT: pick = 32'(src[CNT_MAXLAT]);
            default:    pick = 32'h0000_0000;
        endcase
    endfunction

    assign w_acc     = i_wb_cyc & i_wb_stb & ~r_ack;
    assign w_wr      = w_acc & i_wb_we;
    assign w_hit     = (i_wb_adr[31:16] == BASE[31:16]);
    assign w_off     = i_wb_adr[15:0];
    assign w_is_ctrl = w_hit && (w_off[15:2] == CTRL_OFF[15:2]);
    assign w_is_stat = w_hit && (w_off[15:2] == STATUS_OFF[15:2]);
    // Channel block: 16-byte stride, word 3 of each block is a hole
    assign w_rel     = w_off - CH_BASE;
    assign w_ch_idx  = w_rel / CH_STRIDE;
    assign w_k       = w_rel[3:2];
    assign w_is_chan = w_hit && (w_off >= CH_BASE) && (w_ch_idx < 16'(NCH)) && (w_k != 2'd3);
    assign w_clr_all = w_wr & w_is_ctrl & i_wb_dat[CTRL_CLR];
    assign w_snap    = w_wr & w_is_ctrl & i_wb_dat[CTRL_SNAP];
    assign w_unused  = ^{i_wb_sel, w_off[1:0], i_wb_dat};

    assign w_or[0] = 32'h0000_0000;

    for (genvar c = 0; c < NCH; c++) begin : g_chan
        for (genvar k = 0; k < 3; k++) begin : g_clr
            assign w_cnt_clr[c][k] = w_wr && w_is_chan && (w_ch_idx == 16'(c)) && (w_k == 2'(k));
        end

        assign w_ch_val[c] = (w_is_chan && w_ch_idx == 16'(c)) ?
                             pick(w_live[c], w_shadow[c], r_shrd, w_k) : 32'h0000_0000;
        assign w_or[c+1]   = w_or[c] | w_ch_val[c];

        perf_chan #(.CW(CW), .SAT(SAT)) u_chan (
            .i_clk     (i_clk),
            .i_rst     (i_rst),
            .i_en      (r_en),
            .i_clr_all (w_clr_all),
            .i_snap    (w_snap),
            .i_cnt_clr (w_cnt_clr[c]),
            .i_mon_cyc (i_mon_cyc[c]),
            .i_mon_stb (i_mon_stb[c]),
            .i_mon_ack (i_mon_ack[c]),
            .o_live    (w_live[c]),
            .o_shadow  (w_shadow[c]),
            .o_ovf     (w_ovf[3*c +: 3])
        );
    end

    // Read data mux; unmapped locations read as zero
    always_comb begin
        w_rd = 32'h0000_0000;
        if (w_is_ctrl) begin
            w_rd = {28'h000_0000, r_shrd, 1'b0, 1'b0, r_en};
        end else if (w_is_stat) begin
            w_rd = 32'(r_status);
        end else if (w_is_chan) begin
            w_rd = w_or[NCH];
        end else begin
            w_rd = 32'h0000_0000;
        end
    end

    // Bus handshake: one wait state, single-cycle ack, data latched on access
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ack <= 1'b0;
            r_dat <= 32'h0000_0000;
        end else begin
            r_ack <= w_acc;
            if (w_acc) begin
                r_dat <= i_wb_we ? 32'h0000_0000 : w_rd;
            end
        end
    end

    // CTRL register: EN and SHRD are stored, CLR and SNAP are strobes only
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_en   <= 1'b1;
            r_shrd <= 1'b0;
        end else if (w_wr && w_is_ctrl) begin
            r_en   <= i_wb_dat[CTRL_EN];
            r_shrd <= i_wb_dat[CTRL_SHRD];
        end
    end

    // Sticky overflow flags; a new pulse wins over a coincident W1C
    always_ff @(posedge i_clk) begin
        if (i_rst || w_clr_all) begin
            r_status <= {SW{1'b0}};
        end else if (w_wr && w_is_stat) begin
            r_status <= (r_status & ~i_wb_dat[SW-1:0]) | w_ovf;
        end else begin
            r_status <= r_status | w_ovf;
        end
    end

    assign o_wb_dat = r_dat;
    assign o_wb_ack = r_ack;
    assign o_wb_err = 1'b0;
    assign o_wb_rty = 1'b0;

endmodule

// File: tb/tb_perf_mon.sv
module tb_perf_mon;

    localparam logic [31:0] B = 32'h9900_0000;

    logic        clk = 1'b0;
    logic        rst, cyc, stb, we;
    logic [31:0] adr, wdat;
    logic [3:0]  sel;
    logic [1:0]  mcyc, mstb, mack;
    logic [31:0] dat0, dat1, dat2;
    logic        ack0, ack1, ack2, err0, err1, err2, rty0, rty1, rty2;

    always #5 clk = ~clk;

    perf_mon #(.NCH(2)) u_d0 (
        .i_clk(clk), .i_rst(rst), .i_wb_cyc(cyc), .i_wb_stb(stb), .i_wb_we(we),
        .i_wb_adr(adr), .i_wb_dat(wdat), .i_wb_sel(sel), .o_wb_dat(dat0),
        .o_wb_ack(ack0), .o_wb_err(err0), .o_wb_rty(rty0),
        .i_mon_cyc(mcyc), .i_mon_stb(mstb), .i_mon_ack(mack));

    perf_mon #(.NCH(2), .CW(8), .SAT(1'b0)) u_d1 (
        .i_clk(clk), .i_rst(rst), .i_wb_cyc(cyc), .i_wb_stb(stb), .i_wb_we(we),
        .i_wb_adr(adr), .i_wb_dat(wdat), .i_wb_sel(sel), .o_wb_dat(dat1),
        .o_wb_ack(ack1), .o_wb_err(err1), .o_wb_rty(rty1),
        .i_mon_cyc(mcyc), .i_mon_stb(mstb), .i_mon_ack(mack));

    perf_mon #(.NCH(2), .CW(8), .SAT(1'b1)) u_d2 (
        .i_clk(clk), .i_rst(rst), .i_wb_cyc(cyc), .i_wb_stb(stb), .i_wb_we(we),
        .i_wb_adr(adr), .i_wb_dat(wdat), .i_wb_sel(sel), .o_wb_dat(dat2),
        .o_wb_ack(ack2), .o_wb_err(err2), .o_wb_rty(rty2),
        .i_mon_cyc(mcyc), .i_mon_stb(mstb), .i_mon_ack(mack));

    typedef struct {
        string       tag;
        logic [31:0] exp;
        int          which;
    } exp_t;

    exp_t q_exp[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One Wishbone access; on a read the expected value is popped at ack
    task automatic bus(input logic w, input logic [31:0] a, input logic [31:0] d);
        exp_t        e;
        logic [31:0] obs;
        @(negedge clk);
        chk("ack_idle", {31'b0, ack0}, 32'h0);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d;
        @(posedge clk); #1;
        chk("ack_rise", {31'b0, ack0 & ack1 & ack2}, 32'h1);
        chk("err_rty", {30'b0, err0 | err1 | err2, rty0 | rty1 | rty2}, 32'h0);
        if (!w) begin
            if (q_exp.size() == 0) begin
                chk("sb_underflow", 32'h1, 32'h0);
            end else begin
                e = q_exp.pop_front();
                obs = (e.which == 0) ? dat0 : ((e.which == 1) ? dat1 : dat2);
                chk(e.tag, obs, e.exp);
            end
        end
        @(negedge clk);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(posedge clk); #1;
        chk("ack_fall", {31'b0, ack0}, 32'h0);
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] exp, input int which, input string tag);
        exp_t e;
        e.tag = tag; e.exp = exp; e.which = which;
        q_exp.push_back(e);
        bus(1'b0, a, 32'h0);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        bus(1'b1, a, d);
    endtask

    // Hold monitored signals for n clocks (no trailing idle)
    task automatic mon(input int n, input logic [1:0] c, input logic [1:0] s, input logic [1:0] k);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            mcyc = c; mstb = s; mack = k;
        end
    endtask

    task automatic idle();
        @(negedge clk);
        mcyc = 2'b00; mstb = 2'b00; mack = 2'b00;
    endtask

    initial begin
        rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = 32'h0; wdat = 32'h0;
        sel = 4'hF; mcyc = 2'b00; mstb = 2'b00; mack = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ack", {31'b0, ack0 | ack1 | ack2}, 32'h0);
        chk("rst_dat", dat0 | dat1 | dat2, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // reset register values
        rd(B + 32'h00, 32'h1, 0, "ctrl_rst");
        rd(B + 32'h04, 32'h0, 0, "status_rst");
        rd(B + 32'h10, 32'h0, 0, "req0_rst");

        // ch0: ten request cycles, acks on cycles 4 and 10
        mon(3, 2'b01, 2'b01, 2'b00);
        mon(1, 2'b01, 2'b01, 2'b01);
        mon(5, 2'b01, 2'b01, 2'b00);
        mon(1, 2'b01, 2'b01, 2'b01);
        idle();
        rd(B + 32'h10, 32'd10, 0, "req0");
        rd(B + 32'h14, 32'd2,  0, "ack0");
        rd(B + 32'h18, 32'd6,  0, "maxlat0");
        rd(B + 32'h18, 32'd6,  1, "maxlat0_cw8");
        rd(B + 32'h1C, 32'h0,  0, "hole_1c");
        rd(32'h9901_0010, 32'h0, 0, "off_base");
        rd(B + 32'h20, 32'h0,  0, "req1_idle");
        rd(B + 32'h30, 32'h0,  0, "ch2_oor");
        wr(B + 32'h1C, 32'h0);
        rd(B + 32'h18, 32'd6,  0, "maxlat0_after_hole_wr");

        // EN = 0: ch1 activity is not counted
        wr(B + 32'h00, 32'h0);
        rd(B + 32'h00, 32'h0, 0, "ctrl_en0");
        mon(6, 2'b10, 2'b10, 2'b00);
        mon(1, 2'b10, 2'b10, 2'b10);
        idle();
        rd(B + 32'h20, 32'h0, 0, "req1_dis");
        rd(B + 32'h24, 32'h0, 0, "ack1_dis");
        rd(B + 32'h28, 32'h0, 0, "maxlat1_dis");
        wr(B + 32'h00, 32'h1);
        mon(5, 2'b10, 2'b10, 2'b00);
        idle();
        rd(B + 32'h20, 32'd5, 0, "req1_en");

        // 8-bit counters: wrap versus saturate
        wr(B + 32'h00, 32'h3);
        rd(B + 32'h00, 32'h1, 0, "ctrl_clr_reads0");
        rd(B + 32'h10, 32'h0, 0, "req0_clr");
        mon(257, 2'b01, 2'b01, 2'b00);
        idle();
        rd(B + 32'h10, 32'd1,   1, "req0_wrap");
        rd(B + 32'h04, 32'h1,   1, "status_wrap");
        rd(B + 32'h10, 32'hFF,  2, "req0_sat");
        rd(B + 32'h04, 32'h1,   2, "status_sat");
        rd(B + 32'h10, 32'd257, 0, "req0_cw32");
        rd(B + 32'h04, 32'h0,   0, "status_cw32");
        wr(B + 32'h04, 32'h1);
        rd(B + 32'h04, 32'h0, 1, "status_w1c_wrap");
        rd(B + 32'h04, 32'h0, 2, "status_w1c_sat");
        mon(43, 2'b01, 2'b01, 2'b00);
        idle();
        rd(B + 32'h10, 32'd44,  1, "req0_wrap_300");
        rd(B + 32'h10, 32'hFF,  2, "req0_sat_300");
        rd(B + 32'h04, 32'h1,   2, "status_sat_again");
        rd(B + 32'h04, 32'h0,   1, "status_wrap_quiet");
        rd(B + 32'h10, 32'd300, 0, "req0_cw32_300");

        // saturated latency gives an all-ones MAXLAT candidate
        wr(B + 32'h00, 32'h3);
        mon(260, 2'b01, 2'b01, 2'b00);
        mon(1, 2'b01, 2'b01, 2'b01);
        idle();
        rd(B + 32'h18, 32'hFF,  1, "maxlat0_sat_cw8");
        rd(B + 32'h04, 32'h5,   1, "status_req_lat");
        rd(B + 32'h18, 32'd261, 0, "maxlat0_cw32");
        rd(B + 32'h14, 32'd1,   1, "ack0_cw8");

        // snapshot
        wr(B + 32'h00, 32'h3);
        rd(B + 32'h04, 32'h0, 1, "status_clr_all");
        mon(7, 2'b01, 2'b01, 2'b00);
        idle();
        wr(B + 32'h00, 32'h5);
        mon(3, 2'b01, 2'b01, 2'b00);
        idle();
        wr(B + 32'h00, 32'h9);
        rd(B + 32'h00, 32'h9, 0, "ctrl_shrd");
        rd(B + 32'h10, 32'd7, 0, "req0_shadow");
        rd(B + 32'h10, 32'd7, 2, "req0_shadow_cw8");
        wr(B + 32'h00, 32'h1);
        rd(B + 32'h10, 32'd10, 0, "req0_live");

        // direct counter clear beats a coincident increment
        mon(3, 2'b01, 2'b00, 2'b01);
        idle();
        rd(B + 32'h14, 32'd3, 0, "ack0_before_clr");
        fork
            wr(B + 32'h14, 32'hDEAD_BEEF);
            begin
                @(negedge clk);
                mcyc = 2'b01; mack = 2'b01;
                @(negedge clk);
                mcyc = 2'b00; mack = 2'b00;
            end
        join
        rd(B + 32'h14, 32'h0,  0, "ack0_wr_clr");
        rd(B + 32'h10, 32'd10, 0, "req0_untouched");

        // clear-all keeps shadows
        wr(B + 32'h00, 32'h3);
        rd(B + 32'h10, 32'h0, 0, "req0_clrall");
        rd(B + 32'h14, 32'h0, 0, "ack0_clrall");
        rd(B + 32'h04, 32'h0, 0, "status_clrall");
        wr(B + 32'h00, 32'h9);
        rd(B + 32'h10, 32'd7, 0, "req0_shadow_kept");
        rd(B + 32'h14, 32'h0, 0, "ack0_shadow_kept");

        // reset during an access abandons it
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_mid_ack", {31'b0, ack0}, 32'h0);
        @(negedge clk);
        cyc = 1'b0; stb = 1'b0; rst = 1'b0;
        rd(B + 32'h00, 32'h1, 0, "ctrl_after_rst");

        chk("sb_empty", q_exp.size(), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
